// File: rtl/axi_lite_master_if.sv
// Command/response and AXI4-lite bus bundle for axi_lite_master.
//   master modport : the axi_lite_master side (drives cmd_ready, rsp_*, AW/W/AR, bready, rready)
//   slave  modport : the requester plus the AXI4-lite slave (drives cmd_*, rsp_ready, B/R, readies)
interface axi_lite_master_if #(
  parameter int unsigned C_ADDR_WIDTH = 32
) ();
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned RESP_W = 2;

  // command / response side
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic                    cmd_we;
  logic [C_ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_W-1:0]       cmd_wdata;
  logic [STRB_W-1:0]       cmd_wstrb;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [DATA_W-1:0]       rsp_rdata;
  logic [RESP_W-1:0]       rsp_resp;

  // AXI4-lite side
  logic [C_ADDR_WIDTH-1:0] m_axi_awaddr;
  logic                    m_axi_awvalid;
  logic                    m_axi_awready;
  logic [DATA_W-1:0]       m_axi_wdata;
  logic [STRB_W-1:0]       m_axi_wstrb;
  logic                    m_axi_wvalid;
  logic                    m_axi_wready;
  logic [RESP_W-1:0]       m_axi_bresp;
  logic                    m_axi_bvalid;
  logic                    m_axi_bready;
  logic [C_ADDR_WIDTH-1:0] m_axi_araddr;
  logic                    m_axi_arvalid;
  logic                    m_axi_arready;
  logic [DATA_W-1:0]       m_axi_rdata;
  logic [RESP_W-1:0]       m_axi_rresp;
  logic                    m_axi_rvalid;
  logic                    m_axi_rready;

  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
    input  m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid,
    input  m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_resp,
    output m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
    output m_axi_bready, m_axi_araddr, m_axi_arvalid, m_axi_rready
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
    output m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid,
    output m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_resp,
    input  m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
    input  m_axi_bready, m_axi_araddr, m_axi_arvalid, m_axi_rready
  );
endinterface

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-lite master: one command in, one AXI4-lite write or
// read out, one response back. All bus and response outputs are registered.
//   aclk   : clock, rising edge
//   areset : synchronous active-high reset
//   bus    : axi_lite_master_if.master (command, response and AXI4-lite channels)
module axi_lite_master #(
  parameter int unsigned C_ADDR_WIDTH = 32
) (
  input  logic               aclk,
  input  logic               areset,
  axi_lite_master_if.master  bus
);
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned RESP_W = 2;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_WRESP = 3'd2;
  localparam logic [2:0] S_READ  = 3'd3;
  localparam logic [2:0] S_RDATA = 3'd4;
  localparam logic [2:0] S_RSP   = 3'd5;

  logic [2:0]              r_state,     w_state;
  logic                    r_cmd_ready, w_cmd_ready;
  logic [C_ADDR_WIDTH-1:0] r_awaddr,    w_awaddr;
  logic                    r_awvalid,   w_awvalid;
  logic [DATA_W-1:0]       r_wdata,     w_wdata;
  logic [STRB_W-1:0]       r_wstrb,     w_wstrb;
  logic                    r_wvalid,    w_wvalid;
  logic                    r_bready,    w_bready;
  logic [C_ADDR_WIDTH-1:0] r_araddr,    w_araddr;
  logic                    r_arvalid,   w_arvalid;
  logic                    r_rready,    w_rready;
  logic                    r_rsp_valid, w_rsp_valid;
  logic [DATA_W-1:0]       r_rsp_rdata, w_rsp_rdata;
  logic [RESP_W-1:0]       r_rsp_resp,  w_rsp_resp;

  // A write channel is finished once it has handshaken, now or earlier.
  logic w_aw_hs, w_w_hs, w_aw_done, w_w_done;
  assign w_aw_hs   = r_awvalid & bus.m_axi_awready;
  assign w_w_hs    = r_wvalid  & bus.m_axi_wready;
  assign w_aw_done = ~r_awvalid | bus.m_axi_awready;
  assign w_w_done  = ~r_wvalid  | bus.m_axi_wready;

  // Next-state and next-output logic.
  always_comb begin
    w_state     = r_state;
    w_cmd_ready = r_cmd_ready;
    w_awaddr    = r_awaddr;
    w_awvalid   = r_awvalid;
    w_wdata     = r_wdata;
    w_wstrb     = r_wstrb;
    w_wvalid    = r_wvalid;
    w_bready    = r_bready;
    w_araddr    = r_araddr;
    w_arvalid   = r_arvalid;
    w_rready    = r_rready;
    w_rsp_valid = r_rsp_valid;
    w_rsp_rdata = r_rsp_rdata;
    w_rsp_resp  = r_rsp_resp;

    case (r_state)
      S_IDLE: begin
        // cmd_ready comes up one cycle after reset release.
        w_cmd_ready = 1'b1;
        if (bus.cmd_valid && r_cmd_ready) begin
          w_cmd_ready = 1'b0;
          if (bus.cmd_we) begin
            w_awaddr  = bus.cmd_addr;
            w_wdata   = bus.cmd_wdata;
            w_wstrb   = bus.cmd_wstrb;
            w_awvalid = 1'b1;
            w_wvalid  = 1'b1;
            w_state   = S_WRITE;
          end else begin
            w_araddr  = bus.cmd_addr;
            w_arvalid = 1'b1;
            w_state   = S_READ;
          end
        end
      end

      S_WRITE: begin
        if (w_aw_hs) w_awvalid = 1'b0;
        if (w_w_hs)  w_wvalid  = 1'b0;
        if (w_aw_done && w_w_done) begin
          w_bready = 1'b1;
          w_state  = S_WRESP;
        end
      end

      S_WRESP: begin
        if (bus.m_axi_bvalid) begin
          w_bready    = 1'b0;
          w_rsp_resp  = bus.m_axi_bresp;
          w_rsp_rdata = '0;
          w_rsp_valid = 1'b1;
          w_state     = S_RSP;
        end
      end

      S_READ: begin
        if (bus.m_axi_arready) begin
          w_arvalid = 1'b0;
          w_rready  = 1'b1;
          w_state   = S_RDATA;
        end
      end

      S_RDATA: begin
        if (bus.m_axi_rvalid) begin
          w_rready    = 1'b0;
          w_rsp_rdata = bus.m_axi_rdata;
          w_rsp_resp  = bus.m_axi_rresp;
          w_rsp_valid = 1'b1;
          w_state     = S_RSP;
        end
      end

      S_RSP: begin
        if (bus.rsp_ready) begin
          w_rsp_valid = 1'b0;
          w_cmd_ready = 1'b1;
          w_state     = S_IDLE;
        end
      end

      default: begin
        w_state     = S_IDLE;
        w_cmd_ready = 1'b0;
        w_awvalid   = 1'b0;
        w_wvalid    = 1'b0;
        w_bready    = 1'b0;
        w_arvalid   = 1'b0;
        w_rready    = 1'b0;
        w_rsp_valid = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight transaction.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b0;
      r_awaddr    <= '0;
      r_awvalid   <= 1'b0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_araddr    <= '0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= '0;
    end else begin
      r_state     <= w_state;
      r_cmd_ready <= w_cmd_ready;
      r_awaddr    <= w_awaddr;
      r_awvalid   <= w_awvalid;
      r_wdata     <= w_wdata;
      r_wstrb     <= w_wstrb;
      r_wvalid    <= w_wvalid;
      r_bready    <= w_bready;
      r_araddr    <= w_araddr;
      r_arvalid   <= w_arvalid;
      r_rready    <= w_rready;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_rdata <= w_rsp_rdata;
      r_rsp_resp  <= w_rsp_resp;
    end
  end

  assign bus.cmd_ready     = r_cmd_ready;
  assign bus.m_axi_awaddr  = r_awaddr;
  assign bus.m_axi_awvalid = r_awvalid;
  assign bus.m_axi_wdata   = r_wdata;
  assign bus.m_axi_wstrb   = r_wstrb;
  assign bus.m_axi_wvalid  = r_wvalid;
  assign bus.m_axi_bready  = r_bready;
  assign bus.m_axi_araddr  = r_araddr;
  assign bus.m_axi_arvalid = r_arvalid;
  assign bus.m_axi_rready  = r_rready;
  assign bus.rsp_valid     = r_rsp_valid;
  assign bus.rsp_rdata     = r_rsp_rdata;
  assign bus.rsp_resp      = r_rsp_resp;
endmodule

// File: tb/tb_axi_lite_master.sv
// Self-checking bench for axi_lite_master: behavioural AXI4-lite memory slave
// with configurable stalls/responses, vector table plus hand-written sequences,
// expected responses queued at command time and popped on rsp handshake.
module tb_axi_lite_master;
  logic clk = 1'b0;
  logic areset;
  always #5 clk = ~clk;

  axi_lite_master_if #(.C_ADDR_WIDTH(32)) bus ();
  axi_lite_master #(.C_ADDR_WIDTH(32)) dut (.aclk(clk), .areset(areset), .bus(bus.master));

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  resp;
  } rsp_t;

  rsp_t sb[$];
  int checks = 0;
  int errors = 0;

  // slave configuration
  int          cfg_aw_delay = 0;
  bit          cfg_w_imm    = 1'b0;
  bit          cfg_b_stall  = 1'b0;
  bit          cfg_rd_ovr   = 1'b0;
  logic [31:0] cfg_rdata    = 32'h0;
  logic [1:0]  cfg_resp     = 2'b00;

  // behavioural slave
  logic [31:0] mem [16];
  logic        aw_got, w_got, r_pend;
  logic [31:0] s_awaddr, s_wdata, s_araddr;
  logic [3:0]  s_wstrb;
  int          aw_cnt;

  assign bus.m_axi_awready = !aw_got && (aw_cnt >= cfg_aw_delay);
  assign bus.m_axi_wready  = !w_got && (cfg_w_imm || aw_got);
  assign bus.m_axi_bvalid  = aw_got && w_got && !cfg_b_stall;
  assign bus.m_axi_bresp   = cfg_resp;
  assign bus.m_axi_arready = !r_pend;
  assign bus.m_axi_rvalid  = r_pend;
  assign bus.m_axi_rdata   = cfg_rd_ovr ? cfg_rdata : mem[s_araddr[5:2]];
  assign bus.m_axi_rresp   = cfg_resp;

  always @(posedge clk) begin
    if (areset) begin
      aw_got <= 1'b0; w_got <= 1'b0; r_pend <= 1'b0; aw_cnt <= 0;
      s_awaddr <= '0; s_wdata <= '0; s_araddr <= '0; s_wstrb <= '0;
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else begin
      if (bus.m_axi_awvalid && !bus.m_axi_awready) aw_cnt <= aw_cnt + 1;
      if (bus.m_axi_awvalid && bus.m_axi_awready) begin
        aw_got <= 1'b1; s_awaddr <= bus.m_axi_awaddr; aw_cnt <= 0;
      end
      if (bus.m_axi_wvalid && bus.m_axi_wready) begin
        w_got <= 1'b1; s_wdata <= bus.m_axi_wdata; s_wstrb <= bus.m_axi_wstrb;
      end
      if (bus.m_axi_bvalid && bus.m_axi_bready) begin
        aw_got <= 1'b0; w_got <= 1'b0;
        for (int b = 0; b < 4; b++)
          if (s_wstrb[b]) mem[s_awaddr[5:2]][8*b +: 8] <= s_wdata[8*b +: 8];
      end
      if (bus.m_axi_arvalid && bus.m_axi_arready) begin
        r_pend <= 1'b1; s_araddr <= bus.m_axi_araddr;
      end
      if (bus.m_axi_rvalid && bus.m_axi_rready) r_pend <= 1'b0;
    end
  end

  // write-channel observation counters
  bit          mon_clr = 1'b1;
  int          aw_hi, w_hi;
  bit          aw_unstable, prev_aw;
  logic [31:0] prev_awaddr;
  always @(posedge clk) begin
    if (mon_clr) begin
      aw_hi <= 0; w_hi <= 0; aw_unstable <= 1'b0; prev_aw <= 1'b0; prev_awaddr <= '0;
    end else begin
      if (bus.m_axi_awvalid) aw_hi <= aw_hi + 1;
      if (bus.m_axi_wvalid)  w_hi  <= w_hi + 1;
      if (bus.m_axi_awvalid && prev_aw && bus.m_axi_awaddr !== prev_awaddr) aw_unstable <= 1'b1;
      prev_aw     <= bus.m_axi_awvalid;
      prev_awaddr <= bus.m_axi_awaddr;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", nm);
  endtask

  // Issue one command, check latency/request, optionally hold rsp_ready low, pop and compare.
  task automatic run_cmd(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input logic [31:0] exp_rd, input logic [1:0] exp_rs,
                         input int hold, input int exp_lat, input string nm);
    rsp_t e;
    int   k;
    bit   seen;
    e.rdata = exp_rd;
    e.resp  = exp_rs;
    sb.push_back(e);
    k = 0;
    @(negedge clk);
    while (!bus.cmd_ready && k < 20) begin @(negedge clk); k++; end
    if (!bus.cmd_ready) begin tmo({nm, "_cmd_ready"}); sb.delete(); return; end
    bus.cmd_valid = 1'b1; bus.cmd_we = we; bus.cmd_addr = addr;
    bus.cmd_wdata = wdata; bus.cmd_wstrb = strb;
    bus.rsp_ready = (hold == 0);
    k = 0; seen = 1'b0;
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        bus.cmd_valid = 1'b0;
        if (we) chk({nm, "_awwvalid"}, 32'({bus.m_axi_awvalid, bus.m_axi_wvalid}), 32'h3);
        else    chk({nm, "_arvalid"},  32'(bus.m_axi_arvalid), 32'h1);
      end
      if (bus.rsp_valid) seen = 1'b1;
    end
    if (!seen) begin tmo({nm, "_rsp_valid"}); sb.delete(); return; end
    if (exp_lat != 0) chk({nm, "_latency"}, 32'(k), 32'(exp_lat));
    for (int i = 0; i < hold; i++) begin
      bus.cmd_valid = 1'b1; bus.cmd_we = ~we; bus.cmd_addr = 32'h3C;
      @(negedge clk);
      chk({nm, "_hold_ctl"}, 32'({bus.rsp_valid, bus.cmd_ready, bus.m_axi_awvalid,
                                  bus.m_axi_wvalid, bus.m_axi_arvalid}), 32'h10);
      chk({nm, "_hold_rdata"}, bus.rsp_rdata, sb[0].rdata);
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    e = sb.pop_front();
    chk({nm, "_rdata"}, bus.rsp_rdata, e.rdata);
    chk({nm, "_resp"}, 32'(bus.rsp_resp), 32'(e.resp));
    @(negedge clk);
    chk({nm, "_to_idle"}, 32'({bus.rsp_valid, bus.cmd_ready}), 32'h1);
  endtask

  vec_t vecs[8];

  initial begin
    int k;
    areset = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_we = 1'b0; bus.cmd_addr = '0;
    bus.cmd_wdata = '0; bus.cmd_wstrb = '0; bus.rsp_ready = 1'b1;

    vecs[0] = '{1'b1, 32'h00, 32'h0000_0003, 4'hF, 32'h0, 2'b00};
    vecs[1] = '{1'b1, 32'h04, 32'h0000_0005, 4'hF, 32'h0, 2'b00};
    vecs[2] = '{1'b0, 32'h00, 32'h0,         4'h0, 32'h0000_0003, 2'b00};
    vecs[3] = '{1'b0, 32'h04, 32'h0,         4'h0, 32'h0000_0005, 2'b00};
    vecs[4] = '{1'b1, 32'h0C, 32'h1122_3344, 4'hF, 32'h0, 2'b00};
    vecs[5] = '{1'b1, 32'h0C, 32'hAABB_CCDD, 4'h5, 32'h0, 2'b00};
    vecs[6] = '{1'b0, 32'h0C, 32'h0,         4'h0, 32'h11BB_33DD, 2'b00};
    vecs[7] = '{1'b1, 32'h08, 32'hFFFF_1234, 4'h3, 32'h0, 2'b00};

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_ctl", 32'({bus.cmd_ready, bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_arvalid,
                        bus.m_axi_bready, bus.m_axi_rready, bus.rsp_valid}), 32'h0);
    chk("rst_awaddr", bus.m_axi_awaddr, 32'h0);
    chk("rst_araddr", bus.m_axi_araddr, 32'h0);
    chk("rst_wdata", bus.m_axi_wdata, 32'h0);
    chk("rst_rsp", 32'({bus.rsp_rdata[15:0], bus.rsp_resp, bus.m_axi_wstrb}), 32'h0);
    areset = 1'b0;
    @(negedge clk);
    chk("rst_release_cmd_ready", 32'(bus.cmd_ready), 32'h1);

    // vector table against the default slave timing
    for (int i = 0; i < 8; i++)
      run_cmd(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].strb, vecs[i].exp_rdata,
              vecs[i].exp_resp, 0, vecs[i].we ? 4 : 3, $sformatf("vec%0d", i));
    run_cmd(1'b0, 32'h08, 32'h0, 4'h0, 32'h0000_1234, 2'b00, 0, 3, "partial_rd");

    // AW stalled, W accepted immediately
    cfg_aw_delay = 2; cfg_w_imm = 1'b1;
    @(negedge clk); mon_clr = 1'b0;
    run_cmd(1'b1, 32'h10, 32'h0000_0077, 4'hF, 32'h0, 2'b00, 0, 0, "aw_stall");
    mon_clr = 1'b1;
    chk("aw_stall_aw_cycles", 32'(aw_hi), 32'd3);
    chk("aw_stall_w_cycles", 32'(w_hi), 32'd1);
    chk("aw_stall_addr_stable", 32'(aw_unstable), 32'h0);
    chk("aw_stall_single_rsp", 32'(sb.size()), 32'h0);
    cfg_aw_delay = 0; cfg_w_imm = 1'b0;
    run_cmd(1'b0, 32'h10, 32'h0, 4'h0, 32'h0000_0077, 2'b00, 0, 3, "aw_stall_rd");

    // error responses pass through
    cfg_resp = 2'b10; cfg_rd_ovr = 1'b1; cfg_rdata = 32'hDEAD_BEEF;
    run_cmd(1'b0, 32'h20, 32'h0, 4'h0, 32'hDEAD_BEEF, 2'b10, 0, 3, "slverr_rd");
    cfg_resp = 2'b11;
    run_cmd(1'b1, 32'h24, 32'h1234_5678, 4'hF, 32'h0, 2'b11, 0, 4, "decerr_wr");
    cfg_resp = 2'b00; cfg_rd_ovr = 1'b0;

    // response back-pressure
    run_cmd(1'b0, 32'h0C, 32'h0, 4'h0, 32'h11BB_33DD, 2'b00, 5, 3, "rsp_hold");

    // reset while waiting in WRESP
    cfg_b_stall = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_we = 1'b1; bus.cmd_addr = 32'h18;
    bus.cmd_wdata = 32'h5555_AAAA; bus.cmd_wstrb = 4'hF;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    k = 0;
    while (!bus.m_axi_bready && k < 20) begin @(negedge clk); k++; end
    if (!bus.m_axi_bready) tmo("rst_wresp_reach");
    @(negedge clk);
    areset = 1'b1;
    @(negedge clk);
    chk("rst_wresp_ctl", 32'({bus.cmd_ready, bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_arvalid,
                              bus.m_axi_bready, bus.m_axi_rready, bus.rsp_valid}), 32'h0);
    areset = 1'b0; cfg_b_stall = 1'b0;
    @(negedge clk);
    chk("rst_wresp_cmd_ready", 32'(bus.cmd_ready), 32'h1);
    chk("rst_wresp_no_rsp", 32'(bus.rsp_valid), 32'h0);
    run_cmd(1'b1, 32'h14, 32'h0000_0099, 4'hF, 32'h0, 2'b00, 0, 4, "post_rst_wr");
    run_cmd(1'b0, 32'h14, 32'h0, 4'h0, 32'h0000_0099, 2'b00, 0, 3, "post_rst_rd");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
